// File: rtl/bitop_seq_core.sv
// Multi-cycle bitwise logic core: one ChunkWidth slice of the result per RUN cycle, LSB chunk first.
// Optional running-parity output enabled by defining BITOP_SEQ_CORE_PARITY_EN.
module bitop_seq_core #(
  parameter int Width      = 32,
  parameter int ChunkWidth = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o
`ifdef BITOP_SEQ_CORE_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  localparam int NumChunks = Width / ChunkWidth;
  localparam int CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if ((ChunkWidth > Width) || ((Width % ChunkWidth) != 0)) begin : g_bad_cfg
    $error("bitop_seq_core: Width must be a non-zero multiple of ChunkWidth");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_reg;
  logic [Width-1:0] in0_reg;
  logic [Width-1:0] in1_reg;
  logic [1:0]       op_reg;
  logic [CntW-1:0]  cnt_reg;
  logic [Width-1:0] out_reg;
  logic             ready_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [Width-1:0] res_full;
  logic [Width-1:0] out_next;
  logic             last_chunk;

  always_comb begin
    res_full = '0;
    case (op_reg)
      2'd0:    res_full = in0_reg & in1_reg;
      2'd1:    res_full = in0_reg | in1_reg;
      2'd2:    res_full = in0_reg ^ in1_reg;
      default: res_full = in0_reg & ~in1_reg;
    endcase
  end

  // Only the chunk addressed by the counter takes the new value; others hold.
  for (genvar gi = 0; gi < NumChunks; gi++) begin : g_chunk
    assign out_next[gi*ChunkWidth +: ChunkWidth] =
      ((state_reg == ST_RUN) && (cnt_reg == CntW'(gi))) ?
        res_full[gi*ChunkWidth +: ChunkWidth] : out_reg[gi*ChunkWidth +: ChunkWidth];
  end

  assign last_chunk = (cnt_reg == CntW'(NumChunks - 1));

`ifdef BITOP_SEQ_CORE_PARITY_EN
  logic                 parity_reg;
  logic [NumChunks-1:0] par_sel_vec;
  logic                 cur_par;

  for (genvar gi = 0; gi < NumChunks; gi++) begin : g_par
    assign par_sel_vec[gi] = (cnt_reg == CntW'(gi)) & (^res_full[gi*ChunkWidth +: ChunkWidth]);
  end
  assign cur_par = |par_sel_vec;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_reg <= 1'b0;
    end else if ((state_reg != ST_RUN) && start_i) begin
      parity_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      parity_reg <= parity_reg ^ cur_par;
    end
  end

  assign parity_o = parity_reg;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      in0_reg   <= '0;
      in1_reg   <= '0;
      op_reg    <= 2'd0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          out_reg <= out_next;
          if (last_chunk) begin
            state_reg <= ST_DONE;
            cnt_reg   <= '0;
            done_reg  <= 1'b1;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CntW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          if (start_i) begin
            state_reg <= ST_RUN;
            in0_reg   <= in0_i;
            in1_reg   <= in1_i;
            op_reg    <= op_i;
            cnt_reg   <= '0;
            out_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_o   = out_reg;
  assign ready_o = ready_reg;
  assign busy_o  = busy_reg;
  assign done_o  = done_reg;

endmodule

// File: tb/tb_bitop_seq_core.sv
// Randomized self-checking bench for bitop_seq_core: a 4-chunk instance and a single-chunk instance
// checked against a behavioural result/latency model.
module tb_bitop_seq_core;

  logic        clk;
  logic        rst;
  logic        start0;
  logic        start1;
  logic [1:0]  op_s;
  logic [31:0] a_s;
  logic [31:0] b_s;

  logic [31:0] out0, out1;
  logic        ready0, ready1, busy0, busy1, done0, done1;
`ifdef BITOP_SEQ_CORE_PARITY_EN
  logic        par0, par1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bitop_seq_core #(.Width(32), .ChunkWidth(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start0),
    .op_i    (op_s),
    .in0_i   (a_s),
    .in1_i   (b_s),
    .out_o   (out0),
    .ready_o (ready0),
    .busy_o  (busy0),
    .done_o  (done0)
`ifdef BITOP_SEQ_CORE_PARITY_EN
    ,
    .parity_o(par0)
`endif
  );

  bitop_seq_core #(.Width(32), .ChunkWidth(32)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start1),
    .op_i    (op_s),
    .in0_i   (a_s),
    .in1_i   (b_s),
    .out_o   (out1),
    .ready_o (ready1),
    .busy_o  (busy1),
    .done_o  (done1)
`ifdef BITOP_SEQ_CORE_PARITY_EN
    ,
    .parity_o(par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference result: the operation applied to whole words.
  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (op == 2'd0)      r = a & b;
    else if (op == 2'd1) r = a | b;
    else if (op == 2'd2) r = a ^ b;
    else                 r = a & (~b);
    return r;
  endfunction

  task automatic sample(input int which, output logic [31:0] o, output logic r, output logic b,
                        output logic d, output logic p);
    o = (which == 0) ? out0 : out1;
    r = (which == 0) ? ready0 : ready1;
    b = (which == 0) ? busy0 : busy1;
    d = (which == 0) ? done0 : done1;
    p = 1'b0;
`ifdef BITOP_SEQ_CORE_PARITY_EN
    p = (which == 0) ? par0 : par1;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted operation: latency, handshake flags and result against the model.
  task automatic run_op(input int which, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    logic [31:0] exp, o;
    logic r, bz, d, p;
    int n_exp, busy_cnt, rdy_bad, cyc;
    n_exp = (which == 0) ? 4 : 1;
    exp   = ref_op(op, a, b);
    op_s = op; a_s = a; b_s = b;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    tick();
    start0 = 1'b0; start1 = 1'b0;
    // Scramble inputs after acceptance; the result must not change.
    a_s = $urandom; b_s = $urandom; op_s = 2'($urandom_range(0, 3));
    busy_cnt = 0; rdy_bad = 0; cyc = 0;
    sample(which, o, r, bz, d, p);
    while (!d && cyc < 40) begin
      if (bz) busy_cnt++;
      if (r) rdy_bad++;
      cyc++;
      tick();
      sample(which, o, r, bz, d, p);
    end
    check({tag, "_done"}, 32'(d), 32'd1);
    check({tag, "_busycycles"}, 32'(busy_cnt), 32'(n_exp));
    check({tag, "_readylow"}, 32'(rdy_bad), 32'd0);
    check({tag, "_out"}, o, exp);
    check({tag, "_ready"}, 32'(r), 32'd1);
    check({tag, "_busy0"}, 32'(bz), 32'd0);
`ifdef BITOP_SEQ_CORE_PARITY_EN
    check({tag, "_parity"}, 32'(p), 32'(^exp));
`endif
    tick();
    sample(which, o, r, bz, d, p);
    check({tag, "_pulse"}, 32'(d), 32'd0);
    check({tag, "_hold"}, o, exp);
    check({tag, "_idle_ready"}, 32'(r), 32'd1);
    $display("op which=%0d op=%0d a=%08h b=%08h exp=%08h got=%08h", which, op, a, b, exp, o);
  endtask

  initial begin
    logic [31:0] o, ra, rb, seen_out[$];
    logic r, bz, d, p, drop;
    int seen_idx[$], nd;
    start0 = 0; start1 = 0; op_s = 0; a_s = 0; b_s = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    sample(0, o, r, bz, d, p);
    check("rst_out", o, 32'h0);
    check("rst_ready", 32'(r), 32'd1);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_done", 32'(d), 32'd0);
    check("rst_parity", 32'(p), 32'd0);

    run_op(0, 2'd0, 32'hF0F0_FF00, 32'hFF00_F0F0, "and_dir");
    run_op(0, 2'd1, 32'hA5A5_A5A5, 32'h0F0F_0F0F, "or_dir");
    run_op(0, 2'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F, "xor_dir");
    run_op(0, 2'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, "andn_dir");
    check("const_and", ref_op(2'd0, 32'hF0F0_FF00, 32'hFF00_F0F0), 32'hF000_F000);

    for (int i = 0; i < 12; i++) begin
      run_op(0, 2'($urandom_range(0, 3)), $urandom, $urandom, "rnd");
      repeat ($urandom_range(0, 2)) tick();
    end

    // start held high through RUN with changed operands: one done per accepted start.
    ra = $urandom; rb = $urandom;
    op_s = 2'd2; a_s = ra; b_s = rb; start0 = 1'b1;
    tick();
    a_s = ~ra; b_s = rb ^ 32'h1234_5678;
    drop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample(0, o, r, bz, d, p);
      if (d) begin
        seen_idx.push_back(i);
        seen_out.push_back(o);
        if (seen_idx.size() == 1) drop = 1'b1;
      end
      tick();
      if (drop) start0 = 1'b0;
    end
    nd = seen_idx.size();
    check("b2b_count", 32'(nd), 32'd2);
    if (nd == 2) begin
      check("b2b_first_at", 32'(seen_idx[0]), 32'd4);
      check("b2b_gap", 32'(seen_idx[1] - seen_idx[0]), 32'd5);
      check("b2b_out0", seen_out[0], ra ^ rb);
      check("b2b_out1", seen_out[1], (~ra) ^ (rb ^ 32'h1234_5678));
    end
    $display("b2b dones=%0d", nd);

    // Reset in the second RUN cycle aborts the operation.
    op_s = 2'd1; a_s = 32'hFFFF_FFFF; b_s = 32'h0; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample(0, o, r, bz, d, p);
    check("abort_out", o, 32'h0);
    check("abort_ready", 32'(r), 32'd1);
    check("abort_busy", 32'(bz), 32'd0);
    check("abort_done", 32'(d), 32'd0);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sample(0, o, r, bz, d, p);
      if (d) nd++;
    end
    check("abort_nodone", 32'(nd), 32'd0);
    $display("abort checked");

    // Single-chunk instance.
    run_op(1, 2'd2, 32'hFFFF_FFFF, 32'h0000_0001, "nc1_xor");
    for (int i = 0; i < 4; i++) run_op(1, 2'($urandom_range(0, 3)), $urandom, $urandom, "nc1_rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
